// File: rtl/fnd_pkg.sv
// Glyph constants and the 4-bit -> 7-segment decode shared by the FND scan driver.
// Define FND_HEX_FONT_EN to render codes A-F as hex glyphs; otherwise they blank the digit.
package fnd_pkg;

    // Segment order {dp,g,f,e,d,c,b,a}, active-low.
    localparam logic [7:0] FND_0     = 8'hc0;
    localparam logic [7:0] FND_1     = 8'hf9;
    localparam logic [7:0] FND_2     = 8'ha4;
    localparam logic [7:0] FND_3     = 8'hb0;
    localparam logic [7:0] FND_4     = 8'h99;
    localparam logic [7:0] FND_5     = 8'h92;
    localparam logic [7:0] FND_6     = 8'h82;
    localparam logic [7:0] FND_7     = 8'hf8;
    localparam logic [7:0] FND_8     = 8'h80;
    localparam logic [7:0] FND_9     = 8'h98;
    localparam logic [7:0] FND_A     = 8'h88;
    localparam logic [7:0] FND_B     = 8'h83;
    localparam logic [7:0] FND_C     = 8'hc6;
    localparam logic [7:0] FND_D     = 8'ha1;
    localparam logic [7:0] FND_E     = 8'h86;
    localparam logic [7:0] FND_F     = 8'h8e;
    localparam logic [7:0] FND_BLANK = 8'hff;

    function automatic logic [7:0] fnd_decode(input logic [3:0] code);
        logic [7:0] glyph;
        glyph = FND_BLANK;
        case (code)
            4'h0: glyph = FND_0;
            4'h1: glyph = FND_1;
            4'h2: glyph = FND_2;
            4'h3: glyph = FND_3;
            4'h4: glyph = FND_4;
            4'h5: glyph = FND_5;
            4'h6: glyph = FND_6;
            4'h7: glyph = FND_7;
            4'h8: glyph = FND_8;
            4'h9: glyph = FND_9;
`ifdef FND_HEX_FONT_EN
            4'ha: glyph = FND_A;
            4'hb: glyph = FND_B;
            4'hc: glyph = FND_C;
            4'hd: glyph = FND_D;
            4'he: glyph = FND_E;
            4'hf: glyph = FND_F;
`endif
            default: glyph = FND_BLANK;
        endcase
        return glyph;
    endfunction

endpackage

// File: rtl/fnd_font_rom.sv
// Combinational glyph lookup for one digit code (hex glyphs when FND_HEX_FONT_EN is defined).
module fnd_font_rom
    import fnd_pkg::*;
(
    input  logic [3:0] i_code,
    output logic [7:0] o_glyph
);

    assign o_glyph = fnd_decode(i_code);

endmodule

// File: rtl/fnd_scan_controller.sv
// Time-multiplexed 7-segment scan driver with frame-level double buffering.
// Optional FND_HEX_FONT_EN selects hex glyphs for codes A-F (blank otherwise).
module fnd_scan_controller
    import fnd_pkg::*;
#(
    parameter int DIGITS  = 4,
    parameter int CLK_HZ  = 100_000_000,
    parameter int SCAN_HZ = 1_000
) (
    input  logic                  i_clk,
    input  logic                  i_reset_n,
    input  logic                  i_en,
    input  logic [4*DIGITS-1:0]   i_value,
    input  logic [DIGITS-1:0]     i_dp,
    output logic [7:0]            o_font,
    output logic [DIGITS-1:0]     o_digit
);

    localparam int DIV   = CLK_HZ / SCAN_HZ;
    localparam int PW    = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    if (DIV < 2) begin : g_bad_div
        $error("fnd_scan_controller: CLK_HZ/SCAN_HZ must be at least 2");
    end

    logic [PW-1:0]          r_presc;
    logic [IDX_W-1:0]       r_idx;
    logic [4*DIGITS-1:0]    r_shadow_val;
    logic [DIGITS-1:0]      r_shadow_dp;
    logic                   r_en_d;
    logic [7:0]             r_font;
    logic [DIGITS-1:0]      r_digit;

    logic                   w_run;
    logic                   w_start;
    logic                   w_tick;
    logic                   w_last;
    logic                   w_load;
    logic [3:0]             w_codes [DIGITS];
    logic [3:0]             w_sel_code;
    logic                   w_sel_dp;
    logic [7:0]             w_glyph;
    logic [DIGITS-1:0]      w_digit_sel;

    // The enable-edge cycle only loads the shadow; counting starts on the next one,
    // so the first digit gets a full dwell like every other.
    assign w_start = i_en & ~r_en_d;
    assign w_run   = i_en & r_en_d;
    assign w_tick  = w_run && (r_presc == PW'(DIV - 1));
    assign w_last  = (r_idx == IDX_W'(DIGITS - 1));
    assign w_load  = w_start | (w_tick & w_last);

    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
        assign w_codes[gi]     = r_shadow_val[4*gi +: 4];
        assign w_digit_sel[gi] = (r_idx != IDX_W'(gi));
    end

    assign w_sel_code = w_codes[r_idx];
    assign w_sel_dp   = r_shadow_dp[r_idx];

    fnd_font_rom u_font_rom (
        .i_code  (w_sel_code),
        .o_glyph (w_glyph)
    );

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_presc      <= '0;
            r_idx        <= '0;
            r_shadow_val <= '0;
            r_shadow_dp  <= '0;
            r_en_d       <= 1'b0;
            r_font       <= FND_BLANK;
            r_digit      <= '1;
        end else begin
            r_en_d <= i_en;

            if (!w_run || w_tick) begin
                r_presc <= '0;
            end else begin
                r_presc <= r_presc + 1'b1;
            end

            if (!w_run) begin
                r_idx <= '0;
            end else if (w_tick) begin
                r_idx <= w_last ? '0 : r_idx + 1'b1;
            end

            if (w_load) begin
                r_shadow_val <= i_value;
                r_shadow_dp  <= i_dp;
            end

            if (w_run) begin
                r_digit <= w_digit_sel;
                r_font  <= {w_glyph[7] & ~w_sel_dp, w_glyph[6:0]};
            end else begin
                r_digit <= '1;
                r_font  <= FND_BLANK;
            end
        end
    end

    assign o_font  = r_font;
    assign o_digit = r_digit;

endmodule
